// File: rtl/placement_pkg.sv
// placement_pkg: shared op codes, FSM states and grid constants for placement engines
package placement_pkg;
  typedef enum logic {OP_READ = 1'b0, OP_TAS = 1'b1} op_e;
  typedef enum logic [1:0] {IDLE, ISSUE, EVAL, DONE} state_e;
  localparam int EMPTY = -1;
  function automatic int grid_cells(input int n);
    return n * n;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request after ptr
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] k;
  // scan farthest candidate first so the nearest requester after ptr overwrites it
  always_comb begin
    idx = '0;
    k   = '0;
    for (int i = N; i >= 1; i--) begin
      k = IW'((int'(ptr) + i) % N);
      if (req[k]) idx = k;
    end
    grant = |req ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/grid_access_arbiter.sv
// grid_access_arbiter: round-robin READ / atomic TEST-AND-SET access to a shared grid RAM; GRID_ARB_STATS_EN adds op counters
module grid_access_arbiter #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int GRID_N = 6,
  parameter logic [DATA_W-1:0] EMPTY = DATA_W'(placement_pkg::EMPTY)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          op,
  input  logic [NREQ*ADDR_W-1:0]   addr,
  input  logic [NREQ*DATA_W-1:0]   wdata,
  output logic [NREQ-1:0]          ack,
  output logic [DATA_W-1:0]        rdata,
  output logic                     success,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_din,
  input  logic [DATA_W-1:0]        mem_dout,
  output logic [31:0]              stat_ops,
  output logic [31:0]              stat_fail
);
  import placement_pkg::*;
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [ADDR_W:0] CELLS = (ADDR_W + 1)'(grid_cells(GRID_N));
  state_e state, state_d;
  op_e op_q, op_d;
  logic [IW-1:0] ptr, ptr_d, gidx, gidx_d, pick;
  logic [NREQ-1:0] grant, ack_d;
  logic [DATA_W-1:0] wd_q, wd_d, rdata_d, din_d;
  logic [ADDR_W-1:0] pick_addr, addr_d;
  logic success_d, rd_d, wr_d, hit;
  assign pick_addr = addr[pick*ADDR_W +: ADDR_W];
  assign hit = mem_dout == EMPTY;
  rr_arbiter #(.N(NREQ), .IW(IW)) u_rr (.req(req), .ptr(ptr), .grant(grant), .idx(pick));
  // next-state and next registered outputs; the TAS write is issued straight from the EVAL read so nothing can interleave
  always_comb begin
    state_d   = state;
    ptr_d     = ptr;
    gidx_d    = gidx;
    op_d      = op_q;
    wd_d      = wd_q;
    ack_d     = ack;
    rdata_d   = rdata;
    success_d = success;
    rd_d      = mem_read;
    wr_d      = mem_write;
    addr_d    = mem_addr;
    din_d     = mem_din;
    case (state)
      IDLE: if (|req) begin
        ptr_d  = pick;
        gidx_d = pick;
        op_d   = op_e'(op[pick]);
        wd_d   = wdata[pick*DATA_W +: DATA_W];
        if ({1'b0, pick_addr} < CELLS) begin
          rd_d    = 1'b1;
          addr_d  = pick_addr;
          state_d = ISSUE;
        end else begin
          ack_d     = grant;
          success_d = 1'b0;
          rdata_d   = EMPTY;
          state_d   = DONE;
        end
      end
      ISSUE: begin
        rd_d    = 1'b0;
        state_d = EVAL;
      end
      EVAL: begin
        rdata_d   = mem_dout;
        ack_d     = NREQ'(1) << gidx;
        success_d = op_q == OP_READ || hit;
        wr_d      = op_q == OP_TAS && hit;
        din_d     = (op_q == OP_TAS && hit) ? wd_q : mem_din;
        state_d   = DONE;
      end
      default: begin
        ack_d   = '0;
        wr_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end
  // state and output registers; reset aborts any op in flight and drops the RAM strobes at once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ptr       <= IW'(NREQ - 1);
      gidx      <= '0;
      op_q      <= OP_READ;
      wd_q      <= '0;
      ack       <= '0;
      rdata     <= '0;
      success   <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      gidx      <= gidx_d;
      op_q      <= op_d;
      wd_q      <= wd_d;
      ack       <= ack_d;
      rdata     <= rdata_d;
      success   <= success_d;
      mem_read  <= rd_d;
      mem_write <= wr_d;
      mem_addr  <= addr_d;
      mem_din   <= din_d;
    end
  end
`ifdef GRID_ARB_STATS_EN
  // count completions and lost TAS claims while ack is high
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_ops  <= '0;
      stat_fail <= '0;
    end else if (|ack) begin
      stat_ops <= stat_ops + 32'd1;
      if (op_q == OP_TAS && !success) stat_fail <= stat_fail + 32'd1;
    end
  end
`else
  assign stat_ops  = '0;
  assign stat_fail = '0;
`endif
endmodule

// File: tb/tb_grid_access_arbiter.sv
// tb_grid_access_arbiter: directed vector table plus contention, reset and round-robin sequences
module tb_grid_access_arbiter;
  logic clk = 1'b0, reset_n = 1'b1, init = 1'b1;
  logic [3:0] req = '0, op = '0;
  logic [47:0] addr = '0;
  logic [127:0] wdata = '0;
  logic [3:0] ack;
  logic [31:0] rdata, mem_din, mem_dout, stat_ops, stat_fail;
  logic success, mem_read, mem_write;
  logic [11:0] mem_addr;
  logic [31:0] ram [0:63];
  logic both_hi = 1'b0;
  int checks = 0, failures = 0, cyc = 0;

  typedef struct {
    int          e;
    logic        o;
    logic [11:0] a;
    logic [31:0] w;
    logic        s;
    logic [31:0] rd;
    int          lat;
  } vec_t;
  vec_t tv [10];

  grid_access_arbiter dut (
    .clk(clk), .reset_n(reset_n), .req(req), .op(op), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .success(success), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .stat_ops(stat_ops), .stat_fail(stat_fail)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (mem_read && mem_write) both_hi <= 1'b1;

  always @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < 64; i++) ram[i] <= 32'hFFFF_FFFF;
      ram[20] <= 32'd42;
    end else begin
      if (mem_read) mem_dout <= ram[mem_addr[5:0]];
      if (mem_write) ram[mem_addr[5:0]] <= mem_din;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input int e, input logic o, input logic [11:0] a, input logic [31:0] w);
    req[e] = 1'b1;
    op[e] = o;
    addr[e*12 +: 12] = a;
    wdata[e*32 +: 32] = w;
  endtask

  task automatic wait_ack(output logic seen);
    int k;
    k = 0;
    seen = 1'b0;
    do begin
      @(negedge clk);
      k++;
      seen |= mem_read | mem_write;
    end while (ack == 4'b0 && k < 20);
    chk("ack_timeout", 32'(ack != 4'b0), 32'd1);
  endtask

  initial begin
    int t0, last, n_ops, n_fail;
    logic seen, any_ack;
    tv[0] = '{0, 1'b1, 12'd7,    32'd3,         1'b1, 32'hFFFF_FFFF, 3};
    tv[1] = '{1, 1'b0, 12'd7,    32'd0,         1'b1, 32'd3,         3};
    tv[2] = '{2, 1'b1, 12'd7,    32'd8,         1'b0, 32'd3,         3};
    tv[3] = '{3, 1'b0, 12'd20,   32'd0,         1'b1, 32'd42,        3};
    tv[4] = '{3, 1'b1, 12'd36,   32'd5,         1'b0, 32'hFFFF_FFFF, 1};
    tv[5] = '{1, 1'b0, 12'd4095, 32'd0,         1'b0, 32'hFFFF_FFFF, 1};
    tv[6] = '{2, 1'b1, 12'd35,   32'h7FFF_FFFF, 1'b1, 32'hFFFF_FFFF, 3};
    tv[7] = '{0, 1'b1, 12'd0,    32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFF, 3};
    tv[8] = '{1, 1'b1, 12'd0,    32'd1,         1'b0, 32'hFFFF_FFFE, 3};
    tv[9] = '{3, 1'b0, 12'd35,   32'd0,         1'b1, 32'h7FFF_FFFF, 3};
    n_ops = 0;
    n_fail = 0;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_success", 32'(success), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_din", mem_din, 32'd0);
    chk("rst_stat_ops", stat_ops, 32'd0);
    init = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      drive(tv[i].e, tv[i].o, tv[i].a, tv[i].w);
      t0 = cyc;
      wait_ack(seen);
      chk($sformatf("v%0d_lat", i), 32'(cyc - t0), 32'(tv[i].lat));
      chk($sformatf("v%0d_ack", i), 32'(ack), 32'd1 << tv[i].e);
      chk($sformatf("v%0d_success", i), 32'(success), 32'(tv[i].s));
      chk($sformatf("v%0d_rdata", i), rdata, tv[i].rd);
      chk($sformatf("v%0d_mem_access", i), 32'(seen), 32'(tv[i].lat == 3));
      req[tv[i].e] = 1'b0;
      @(negedge clk);
      if (tv[i].a < 12'd36)
        chk($sformatf("v%0d_cell", i), ram[tv[i].a[5:0]], (tv[i].o && tv[i].s) ? tv[i].w : tv[i].rd);
      @(negedge clk);
      n_ops++;
      if (tv[i].o && !tv[i].s) n_fail++;
    end
`ifdef GRID_ARB_STATS_EN
    chk("stat_ops", stat_ops, 32'(n_ops));
    chk("stat_fail", stat_fail, 32'(n_fail));
`else
    chk("stat_ops_off", stat_ops, 32'd0);
    chk("stat_fail_off", stat_fail, 32'd0);
`endif

    drive(1, 1'b1, 12'd14, 32'd5);
    drive(2, 1'b1, 12'd14, 32'd9);
    t0 = cyc;
    wait_ack(seen);
    chk("cont1_lat", 32'(cyc - t0), 32'd3);
    chk("cont1_ack", 32'(ack), 32'b0010);
    chk("cont1_success", 32'(success), 32'd1);
    chk("cont1_rdata", rdata, 32'hFFFF_FFFF);
    req[1] = 1'b0;
    wait_ack(seen);
    chk("cont2_lat", 32'(cyc - t0), 32'd7);
    chk("cont2_ack", 32'(ack), 32'b0100);
    chk("cont2_success", 32'(success), 32'd0);
    chk("cont2_rdata", rdata, 32'd5);
    req[2] = 1'b0;
    @(negedge clk);
    chk("cont_cell", ram[14], 32'd5);
    @(negedge clk);

    drive(0, 1'b1, 12'd30, 32'd77);
    repeat (2) @(negedge clk);
    chk("pre_rst_addr", 32'(mem_addr), 32'd30);
    reset_n = 1'b0;
    req = '0;
    #1;
    chk("midrst_ack", 32'(ack), 32'd0);
    chk("midrst_rdata", rdata, 32'd0);
    chk("midrst_success", 32'(success), 32'd0);
    chk("midrst_mem_read", 32'(mem_read), 32'd0);
    chk("midrst_mem_write", 32'(mem_write), 32'd0);
    chk("midrst_mem_addr", 32'(mem_addr), 32'd0);
    chk("midrst_mem_din", mem_din, 32'd0);
    chk("midrst_stat_ops", stat_ops, 32'd0);
    chk("midrst_stat_fail", stat_fail, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    any_ack = 1'b0;
    repeat (4) begin
      @(negedge clk);
      any_ack |= |ack | mem_write;
    end
    chk("midrst_no_ack_write", 32'(any_ack), 32'd0);
    chk("midrst_cell", ram[30], 32'hFFFF_FFFF);

    for (int k = 0; k < 4; k++) drive(k, 1'b0, 12'(k), 32'd0);
    last = 0;
    for (int i = 0; i < 8; i++) begin
      wait_ack(seen);
      chk($sformatf("rr%0d_ack", i), 32'(ack), 32'd1 << (i % 4));
      chk($sformatf("rr%0d_rdata", i), rdata, (i % 4 == 0) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF);
      if (i > 0) chk($sformatf("rr%0d_gap", i), 32'(cyc - last >= 4), 32'd1);
      last = cyc;
      req[i % 4] = 1'b0;
      @(negedge clk);
      chk($sformatf("rr%0d_pulse", i), 32'(ack), 32'd0);
      @(negedge clk);
      req[i % 4] = 1'b1;
    end
    req = '0;
    repeat (6) @(negedge clk);
    chk("no_rd_wr_overlap", 32'(both_hi), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
